// File: rtl/stage_ack_responder.sv
// rtl/stage_ack_responder.sv - four-phase request responder for the async controller's pipeline stages
// Synchronises five req lines, models per-stage work latency, returns acks, flags errors, counts retires.

module stage_ack_sync2 #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

module stage_ack_channel (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       req_s_i,
    input  logic [3:0] lat_i,
    output logic       ack_o,
    output logic       busy_o,
    output logic       err_evt_o,
    output logic       retire_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ack_q;
    logic       busy_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_evt_o = 1'b0;
        retire_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s_i) begin
                    if (lat_i == 4'd0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = lat_i - 4'd1;
                    end
                end
            end
            ST_BUSY: begin
                // Requester withdrew before the work finished: abandon without acking.
                if (!req_s_i) begin
                    err_evt_o = 1'b1;
                    state_d   = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_s_i) begin
                    state_d  = ST_IDLE;
                    retire_o = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ack and busy decode the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == ST_ACK);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign ack_o  = ack_q;
    assign busy_o = busy_q;
endmodule

module stage_ack_responder #(
    parameter int LAT1    = 1,
    parameter int LAT2_1  = 1,
    parameter int LAT2_2  = 1,
    parameter int MEM_LAT = 4,
    parameter int LAT4    = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             req1,
    input  logic             req2_1,
    input  logic             req2_2,
    input  logic             req3,
    input  logic             req4,
    input  logic             err_clr,
    output logic             ack1,
    output logic             ack2_1,
    output logic             ack2_2,
    output logic             ack3,
    output logic             ack4,
    output logic             busy,
    output logic [4:0]       err,
    output logic [CNT_W-1:0] instr_count
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [4:0]       req_s;
    logic [4:0]       ack_v;
    logic [4:0]       busy_v;
    logic [4:0]       err_evt_v;
    logic [4:0]       retire_v;
    logic [3:0]       lat [5];
    logic [3:0]       lat3;
    logic [4:0]       err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;

    stage_ack_sync2 #(.W(5)) u_sync (
        .clk_i    (clk),
        .resetn_i (reset),
        .d_i      ({req4, req3, req2_2, req2_1, req1}),
        .q_o      (req_s)
    );

    // Only memory ops spend time in stage 3; lat3 is consumed solely on the IDLE exit edge.
    assign lat3   = ((opcode == OP_LOAD) || (opcode == OP_STORE)) ? 4'(MEM_LAT) : 4'd0;
    assign lat[0] = 4'(LAT1);
    assign lat[1] = 4'(LAT2_1);
    assign lat[2] = 4'(LAT2_2);
    assign lat[3] = lat3;
    assign lat[4] = 4'(LAT4);

    for (genvar g = 0; g < 5; g++) begin : g_ch
        stage_ack_channel u_ch (
            .clk_i     (clk),
            .resetn_i  (reset),
            .req_s_i   (req_s[g]),
            .lat_i     (lat[g]),
            .ack_o     (ack_v[g]),
            .busy_o    (busy_v[g]),
            .err_evt_o (err_evt_v[g]),
            .retire_o  (retire_v[g])
        );
    end

    // A fresh error wins over a simultaneous clear so no event is lost.
    assign err_d   = (err_clr ? 5'd0 : err_q) | err_evt_v;
    assign count_d = count_q + CNT_W'(retire_v[4]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q   <= 5'd0;
            count_q <= '0;
        end else begin
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign ack1        = ack_v[0];
    assign ack2_1      = ack_v[1];
    assign ack2_2      = ack_v[2];
    assign ack3        = ack_v[3];
    assign ack4        = ack_v[4];
    assign busy        = |busy_v;
    assign err         = err_q;
    assign instr_count = count_q;
endmodule
